wave_sequencer: RTL
===================

Name: wave_sequencer

Overview:
Programmable stimulus sequencer built around a free-running-style phase counter. It gates the counter (start/pause/stop), programs its terminal count and number of loops, and derives N_CH timing windows (rdy/start/req/ack-style pulses) from per-channel compare registers. Used as the shared timing source feeding property-check exercises and bench stimulus in place of hard-wired compare decodes.

Parameters:
CNT_W, 4, phase counter width
N_CH, 4, number of window channels
LOOP_W, 4, width of loop-count field (0 = run forever)

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_we  in  1  write window config for channel cfg_ch
cfg_ch  in  $clog2(N_CH)  channel index
cfg_en  in  1  channel enable
cfg_lo  in  CNT_W  window first count (inclusive)
cfg_hi  in  CNT_W  window last count (inclusive)
period  in  CNT_W  terminal count; sampled on accepted start
loops  in  LOOP_W  number of full periods; sampled on accepted start
cmd_start  in  1  start from IDLE/DONE, resume from PAUSE
cmd_pause  in  1  freeze counter in RUN
cmd_stop  in  1  abort to IDLE
count  out  CNT_W  current phase
ch_out  out  N_CH  window outputs
busy  out  1  state is RUN or PAUSE
wrap  out  1  one-cycle pulse on count==period_q in RUN
done  out  1  one-cycle pulse on entry to DONE
cfg_err  out  1  one-cycle pulse on rejected config write

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs 0, state IDLE, all channel configs cleared (en=0, lo=0, hi=0), period_q=0, loops_q=0, loop_cnt=0.
- FSM states IDLE, RUN, PAUSE, DONE. Command priority per cycle: stop > pause > start.
- IDLE/DONE + cmd_start: capture period_q=period, loops_q=loops, loop_cnt=0, count=0, next RUN. cmd_pause ignored here.
- RUN: count increments each cycle; at count==period_q, next count=0, wrap=1 same cycle, loop_cnt+1. If loops_q!=0 and loop_cnt==loops_q-1 at wrap: next state DONE, count=0, done=1 the first DONE cycle.
- RUN + cmd_pause: next PAUSE, count holds; the pausing cycle itself does not advance count. PAUSE + cmd_start: next RUN, counting resumes next cycle. PAUSE + cmd_pause: no effect.
- cmd_start in RUN: ignored (no restart).
- cmd_stop in any state: next IDLE, count=0, loop_cnt=0, no done/wrap pulse that cycle.
- period_q=0: count stays 0, wrap every RUN cycle; with loops_q=N, DONE after N cycles.
- Full width: period=2^CNT_W-1 wraps naturally; no overflow beyond period_q.
- ch_out[i] = busy & en[i] & (lo[i] <= count <= hi[i]), combinational from registered count/state; zero latency relative to count. lo==hi gives a one-count window. Windows beyond period_q never assert. In PAUSE ch_out holds the value for the frozen count.
- Config write: accepted only when !busy and cfg_lo<=cfg_hi and cfg_ch<N_CH; takes effect next cycle. Otherwise not written and cfg_err=1 next cycle. cfg_we coincident with accepted cmd_start: write accepted (state still not busy).
- Reset mid-operation: immediate return to reset values, no done pulse.

Decomposition:
- Package wave_seq_pkg: state enum (IDLE, RUN, PAUSE, DONE), channel config struct {en, lo, hi}, default CNT_W/N_CH/LOOP_W constants.
- One sub-module natural: wave_window (single channel compare: config register + inclusive range decode), instantiated N_CH times by generate; FSM, counter and loop counter in top.

Test Plan:
- Cfg ch0 lo=1 hi=2, ch1 lo=5 hi=5; period=9, loops=1, start -> count 0..9, ch0 high at counts 1,2, ch1 at 5, wrap at 9, done one cycle later, count=0, busy=0.
- period=3, loops=0, start, pause at count=2 for 4 cycles, start -> count holds 2, ch_out frozen, then 3,0,1,...; wrap every 4 counting cycles, never done.
- Running, cmd_stop and cmd_pause same cycle -> IDLE, count=0, ch_out=0, no done.
- cfg_we while busy, and cfg_lo=7 cfg_hi=3 while idle -> cfg_err pulse each, channel config unchanged on readback via ch_out.
- period=0, loops=3 -> wrap 3 consecutive cycles, done on 4th; period=15, loops=2 -> done after 32 RUN cycles, ch lo=15 hi=15 asserts twice.
- Assert rst at count=6 in RUN -> all outputs 0 immediately, state IDLE; subsequent start behaves as fresh.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// rtl/wave_seq_pkg.sv - shared types and default sizes for the wave sequencer
package wave_seq_pkg;

   localparam int CNT_W_DEF  = 4;
   localparam int N_CH_DEF   = 4;
   localparam int LOOP_W_DEF = 4;
   // Window bounds are stored at this width so one struct serves every CNT_W.
   localparam int CNT_W_MAX  = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_e;

   typedef struct packed {
      logic                 en;
      logic [CNT_W_MAX-1:0] lo;
      logic [CNT_W_MAX-1:0] hi;
   } ch_cfg_t;

endpackage

// File: rtl/wave_sequencer_if.sv
// rtl/wave_sequencer_if.sv - config, command and status bundle of the wave sequencer
interface wave_sequencer_if
   import wave_seq_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int N_CH   = N_CH_DEF,
   parameter int LOOP_W = LOOP_W_DEF
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic              cfg_en;
   logic [CNT_W-1:0]  cfg_lo;
   logic [CNT_W-1:0]  cfg_hi;
   logic [CNT_W-1:0]  period;
   logic [LOOP_W-1:0] loops;
   logic              cmd_start;
   logic              cmd_pause;
   logic              cmd_stop;
   logic [CNT_W-1:0]  count;
   logic [N_CH-1:0]   ch_out;
   logic              busy;
   logic              wrap;
   logic              done;
   logic              cfg_err;

   modport master (
      output cfg_we, cfg_ch, cfg_en, cfg_lo, cfg_hi, period, loops,
             cmd_start, cmd_pause, cmd_stop,
      input  count, ch_out, busy, wrap, done, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_en, cfg_lo, cfg_hi, period, loops,
             cmd_start, cmd_pause, cmd_stop,
      output count, ch_out, busy, wrap, done, cfg_err
   );

endinterface

// File: rtl/wave_sequencer_window.sv
// rtl/wave_sequencer_window.sv - one channel: config register plus inclusive range decode
module wave_window
   import wave_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] lo_i,
   input  logic [CNT_W-1:0] hi_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             busy_i,
   output logic             hit_o
);
   ch_cfg_t              cfg_q;
   ch_cfg_t              cfg_d;
   logic [CNT_W_MAX-1:0] count_x;

   always_comb begin
      cfg_d = cfg_q;
      if (we_i) begin
         cfg_d.en = en_i;
         cfg_d.lo = CNT_W_MAX'(lo_i);
         cfg_d.hi = CNT_W_MAX'(hi_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

   assign count_x = CNT_W_MAX'(count_i);
   assign hit_o   = busy_i & cfg_q.en & (cfg_q.lo <= count_x) & (count_x <= cfg_q.hi);

endmodule

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - gated phase counter with loop control and N_CH compare windows
module wave_sequencer
   import wave_seq_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int N_CH   = N_CH_DEF,
   parameter int LOOP_W = LOOP_W_DEF
) (
   input logic              clk,
   input logic              rst,
   wave_sequencer_if.slave  bus
);
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [LOOP_W-1:0] loops_q, loops_d;
   logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
   logic              done_q, done_d;
   logic              cfg_err_q, cfg_err_d;
   logic              busy;
   logic              at_term;
   logic              last_loop;
   logic              wrap;
   logic              cfg_ok;
   logic [N_CH-1:0]   ch_we;
   logic [N_CH-1:0]   ch_hit;

   assign busy      = (state_q == RUN) || (state_q == PAUSE);
   assign at_term   = (count_q == period_q);
   assign last_loop = (loops_q != '0) && ((loop_cnt_q + LOOP_W'(1)) == loops_q);
   assign cfg_ok    = !busy && (bus.cfg_lo <= bus.cfg_hi) && (int'(bus.cfg_ch) < N_CH);

   // Stop outranks everything; pause only matters in RUN, start only outside RUN.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      period_d   = period_q;
      loops_d    = loops_q;
      loop_cnt_d = loop_cnt_q;
      done_d     = 1'b0;
      wrap       = 1'b0;
      cfg_err_d  = bus.cfg_we & ~cfg_ok;
      if (bus.cmd_stop) begin
         state_d    = IDLE;
         count_d    = '0;
         loop_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.cmd_start) begin
                  state_d    = RUN;
                  period_d   = bus.period;
                  loops_d    = bus.loops;
                  loop_cnt_d = '0;
                  count_d    = '0;
               end
            end
            RUN: begin
               if (bus.cmd_pause) begin
                  state_d = PAUSE;
               end else if (at_term) begin
                  wrap       = 1'b1;
                  count_d    = '0;
                  loop_cnt_d = loop_cnt_q + LOOP_W'(1);
                  if (last_loop) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            PAUSE: begin
               if (bus.cmd_start) begin
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         period_q   <= '0;
         loops_q    <= '0;
         loop_cnt_q <= '0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         period_q   <= period_d;
         loops_q    <= loops_d;
         loop_cnt_q <= loop_cnt_d;
         done_q     <= done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_win
      assign ch_we[i] = bus.cfg_we & cfg_ok & (int'(bus.cfg_ch) == i);

      wave_window #(.CNT_W(CNT_W)) u_win (
         .clk     (clk),
         .rst     (rst),
         .we_i    (ch_we[i]),
         .en_i    (bus.cfg_en),
         .lo_i    (bus.cfg_lo),
         .hi_i    (bus.cfg_hi),
         .count_i (count_q),
         .busy_i  (busy),
         .hit_o   (ch_hit[i])
      );
   end

   assign bus.count   = count_q;
   assign bus.ch_out  = ch_hit;
   assign bus.busy    = busy;
   assign bus.wrap    = wrap;
   assign bus.done    = done_q;
   assign bus.cfg_err = cfg_err_q;

endmodule
